// File: rtl/sample_serializer.sv
// Codec-side sample serializer: requests one mono sample per frame and shifts it
// MSB-first into both slots of a bclk/lrclk/sdata link, replaying the last sample on underrun.
module sample_serializer #(
    parameter int unsigned BCLK_HALF = 4,
    parameter int unsigned WIDTH     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    output logic             generate_next_sample,
    input  logic             new_sample_ready,
    input  logic [WIDTH-1:0] sample_in,
    output logic             bclk,
    output logic             lrclk,
    output logic             sdata,
    output logic [7:0]       underrun_count
);

    localparam int unsigned BIT_CLKS = 2 * BCLK_HALF;
    localparam int unsigned PHW      = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
    localparam int unsigned BITW     = 5;
    localparam int unsigned CNTW     = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HAVE = 2'd2
    } state_t;

    // Frame position is kept as (bit, phase) so no divider is needed: pos = bit*BIT_CLKS + ph.
    state_t            state_q, state_d;
    logic [PHW-1:0]    ph_q, ph_d;
    logic [BITW-1:0]   bit_q, bit_d;
    logic [WIDTH-1:0]  play_q, play_d;
    logic [WIDTH-1:0]  next_q, next_d;
    logic [CNTW-1:0]   ucnt_q, ucnt_d;
    logic              gen_q, gen_d;
    logic              bclk_q, bclk_d;
    logic              lrclk_q, lrclk_d;
    logic              sdata_q, sdata_d;
    logic              last_c;

    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        bit_d   = bit_q;
        play_d  = play_q;
        next_d  = next_q;
        ucnt_d  = ucnt_q;
        last_c  = (bit_q == BITW'(31)) && (ph_q == PHW'(BIT_CLKS - 1));

        if (!enable) begin
            state_d = S_IDLE;
            ph_d    = '0;
            bit_d   = '0;
            play_d  = '0;
            next_d  = '0;
        end else if (state_q == S_IDLE) begin
            // Fresh start: the first enabled cycle is pos 0 and carries the request.
            state_d = S_WAIT;
            ph_d    = '0;
            bit_d   = '0;
        end else begin
            if (ph_q == PHW'(BIT_CLKS - 1)) begin
                ph_d  = '0;
                bit_d = bit_q + BITW'(1);
            end else begin
                ph_d  = ph_q + PHW'(1);
            end

            if (last_c) begin
                state_d = S_WAIT;
                if (state_q == S_HAVE) begin
                    play_d = next_q;
                end else if (new_sample_ready) begin
                    play_d = sample_in;
                end else if (ucnt_q != CNTW'(255)) begin
                    ucnt_d = ucnt_q + CNTW'(1);
                end
            end else if ((state_q == S_WAIT) && new_sample_ready) begin
                next_d  = sample_in;
                state_d = S_HAVE;
            end
        end

        // Outputs decode the next position so the registered values line up with pos.
        gen_d   = enable && (bit_d == '0) && (ph_d == '0);
        bclk_d  = enable && (ph_d >= PHW'(BCLK_HALF));
        lrclk_d = enable && bit_d[4];
        sdata_d = enable && play_d[4'(4'd15 - bit_d[3:0])];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            ph_q    <= '0;
            bit_q   <= '0;
            play_q  <= '0;
            next_q  <= '0;
            ucnt_q  <= '0;
            gen_q   <= 1'b0;
            bclk_q  <= 1'b0;
            lrclk_q <= 1'b0;
            sdata_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            bit_q   <= bit_d;
            play_q  <= play_d;
            next_q  <= next_d;
            ucnt_q  <= ucnt_d;
            gen_q   <= gen_d;
            bclk_q  <= bclk_d;
            lrclk_q <= lrclk_d;
            sdata_q <= sdata_d;
        end
    end

    assign generate_next_sample = gen_q;
    assign bclk                 = bclk_q;
    assign lrclk                = lrclk_q;
    assign sdata                = sdata_q;
    assign underrun_count       = ucnt_q;

endmodule

// File: tb/tb_sample_serializer.sv
// Scoreboard bench for sample_serializer: stimulus queues the expected word and underrun
// count per complete frame; a negedge monitor deserializes each frame and compares.
module tb_sample_serializer;

    localparam int BH    = 2;
    localparam int TW    = 2 * BH;
    localparam int FRAME = 64 * BH;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        generate_next_sample;
    logic        new_sample_ready;
    logic [15:0] sample_in;
    logic        bclk;
    logic        lrclk;
    logic        sdata;
    logic [7:0]  underrun_count;

    typedef struct packed {
        logic [15:0] word;
        logic [7:0]  ucnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    sample_serializer #(.BCLK_HALF(BH), .WIDTH(16)) dut (
        .clk                  (clk),
        .reset                (reset),
        .enable               (enable),
        .generate_next_sample (generate_next_sample),
        .new_sample_ready     (new_sample_ready),
        .sample_in            (sample_in),
        .bclk                 (bclk),
        .lrclk                (lrclk),
        .sdata                (sdata),
        .underrun_count       (underrun_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] w, input logic [7:0] c);
        exp_t e;
        e.word = w;
        e.ucnt = c;
        exp_q.push_back(e);
    endtask

    // Drive one frame of responder activity starting from the pos=0 cycle; -1 means no pulse.
    task automatic run_frame(input int p1, input logic [15:0] d1, input int p2, input logic [15:0] d2);
        for (int p = 0; p < FRAME; p++) begin
            new_sample_ready = (p == p1) || (p == p2);
            sample_in        = (p == p1) ? d1 : ((p == p2) ? d2 : 16'h0000);
            tick();
        end
        new_sample_ready = 1'b0;
        sample_in        = 16'h0000;
    endtask

    function automatic logic [31:0] outs();
        return {28'd0, generate_next_sample, bclk, lrclk, sdata};
    endfunction

    // Monitor: rebuilds each full frame from the link and checks it against the scoreboard.
    int          tpos = 0;
    int          shape_err = 0;
    logic [31:0] word = '0;
    bit          in_frame = 1'b0;
    bit          expect_gen = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (reset || !enable) begin
            in_frame   = 1'b0;
            expect_gen = 1'b0;
        end else begin
            if (expect_gen) check("next_req", 32'(generate_next_sample), 32'd1);
            expect_gen = 1'b0;
            if (generate_next_sample) begin
                if (in_frame) check("early_req", 32'(tpos), 32'(FRAME - 1));
                in_frame  = 1'b1;
                tpos      = 0;
                shape_err = 0;
                word      = '0;
            end else if (in_frame) begin
                tpos++;
            end
            if (in_frame) begin
                if (bclk !== ((tpos % TW) >= BH)) shape_err++;
                if (lrclk !== ((tpos / TW) >= 16)) shape_err++;
                if (generate_next_sample !== (tpos == 0)) shape_err++;
                if ((tpos % TW) == BH) word = {word[30:0], sdata};
                if (tpos == FRAME - 1) begin
                    if (exp_q.size() == 0) begin
                        check("queue_has_entry", 32'd0, 32'd1);
                    end else begin
                        e = exp_q.pop_front();
                        check("left_slot",  32'(word[31:16]), 32'(e.word));
                        check("right_slot", 32'(word[15:0]),  32'(e.word));
                        check("link_shape", 32'(shape_err),   32'd0);
                        check("underrun",   32'(underrun_count), 32'(e.ucnt));
                    end
                    in_frame   = 1'b0;
                    expect_gen = 1'b1;
                end
            end
        end
    end

    initial begin
        int seen;
        reset            = 1'b1;
        enable           = 1'b0;
        new_sample_ready = 1'b0;
        sample_in        = 16'h0000;
        repeat (3) tick();
        check("reset_outs", outs(), 32'd0);
        check("reset_ucnt", 32'(underrun_count), 32'd0);
        reset = 1'b0;

        // Idle with enable low: nothing moves, ready is ignored.
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            new_sample_ready = (i % 7 == 3);
            sample_in        = 16'hBEEF;
            tick();
            if (outs() != 32'd0) seen++;
        end
        new_sample_ready = 1'b0;
        check("idle_activity", 32'(seen), 32'd0);
        check("idle_ucnt", 32'(underrun_count), 32'd0);

        enable = 1'b1;
        tick();
        check("start_req", 32'(generate_next_sample), 32'd1);

        push(16'h0000, 8'd0); run_frame(10, 16'hA5C3, -1, 16'h0);
        push(16'hA5C3, 8'd0); run_frame(10, 16'h8000, -1, 16'h0);
        push(16'h8000, 8'd0); run_frame(-1, 16'h0, -1, 16'h0);
        push(16'h8000, 8'd1); run_frame(FRAME - 1, 16'h7FFF, -1, 16'h0);
        push(16'h7FFF, 8'd1); run_frame(0, 16'h00FF, 20, 16'h1234);
        push(16'h00FF, 8'd1); run_frame(50, 16'hC001, -1, 16'h0);

        // Drop enable at pos 100 of the frame that would have played 0xC001.
        for (int p = 0; p < 100; p++) tick();
        enable = 1'b0;
        tick();
        check("disable_outs", outs(), 32'd0);
        check("disable_ucnt", 32'(underrun_count), 32'd1);
        new_sample_ready = 1'b1;
        sample_in        = 16'h5555;
        repeat (5) tick();
        check("disabled_ready_outs", outs(), 32'd0);
        new_sample_ready = 1'b0;
        enable = 1'b1;
        tick();
        check("reenable_req", 32'(generate_next_sample), 32'd1);

        push(16'h0000, 8'd1); run_frame(-1, 16'h0, -1, 16'h0);
        for (int k = 8; k < 266; k++) begin
            push(16'h0000, (k - 6 > 255) ? 8'd255 : 8'(k - 6));
            run_frame(-1, 16'h0, -1, 16'h0);
        end
        check("sat_ucnt", 32'(underrun_count), 32'd255);

        // Asynchronous reset mid-frame at pos 70 (bclk and lrclk both high there).
        for (int p = 0; p < 70; p++) tick();
        check("pre_reset_outs", outs(), 32'b0110);
        reset  = 1'b1;
        enable = 1'b0;
        #1;
        check("async_reset_outs", outs(), 32'd0);
        check("async_reset_ucnt", 32'(underrun_count), 32'd0);
        repeat (2) tick();
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (generate_next_sample) seen++;
        end
        check("post_reset_no_req", 32'(seen), 32'd0);
        enable = 1'b1;
        tick();
        check("post_reset_req", 32'(generate_next_sample), 32'd1);
        push(16'h0000, 8'd0); run_frame(5, 16'h1234, -1, 16'h0);
        push(16'h1234, 8'd0); run_frame(-1, 16'h0, -1, 16'h0);

        enable = 1'b0;
        repeat (3) tick();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
